regfile_sequencer: RTL

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

---
 rtl/regfile_sequencer_if.sv | 33 +++
 rtl/regfile_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer_if.sv
// Command handshake bundle for regfile_sequencer.
//   cmd_valid  : command offered by the master
//   cmd_ready  : sequencer can accept a command (high only while idle)
//   cmd_op     : opcode (NOP, LDI, MOV, CLR, INC, DEC, SWAP, reserved)
//   cmd_dst    : destination register index (0-3 = R1-R4, 4-7 = S1-S4)
//   cmd_src    : source register index
//   cmd_imm    : immediate data for LDI
interface regfile_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_dst;
    logic [2:0]  cmd_src;
    logic [31:0] cmd_imm;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_dst,
        output cmd_src,
        output cmd_imm,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_dst,
        input  cmd_src,
        input  cmd_imm,
        output cmd_ready
    );
endinterface

// File: rtl/regfile_sequencer.sv
// Sequences single register-file commands into RegSel/ScrSel/FunSel/OutASel/I controls.
//   clock    : sole clock, rising edge
//   reset    : asynchronous active-high reset
//   cmd      : command handshake (slave side)
//   rf_outa  : registered OutA data from the register file
//   RegSel   : one-hot write enable for R1-R4
//   ScrSel   : one-hot write enable for S1-S4
//   FunSel   : register function (000 CLR, 001 LOAD, 010 INC, 011 DEC)
//   OutASel  : read select A
//   OutBSel  : read select B, always 000
//   I        : write data to the register file
//   done     : one-cycle completion pulse
//   err      : one-cycle pulse with done for a rejected command
module regfile_sequencer (
    input  logic                 clock,
    input  logic                 reset,
    regfile_sequencer_if.slave   cmd,
    input  logic [31:0]          rf_outa,
    output logic [3:0]           RegSel,
    output logic [3:0]           ScrSel,
    output logic [2:0]           FunSel,
    output logic [2:0]           OutASel,
    output logic [2:0]           OutBSel,
    output logic [31:0]          I,
    output logic                 done,
    output logic                 err
);

    localparam logic [2:0] OpNop  = 3'b000;
    localparam logic [2:0] OpLdi  = 3'b001;
    localparam logic [2:0] OpMov  = 3'b010;
    localparam logic [2:0] OpClr  = 3'b011;
    localparam logic [2:0] OpInc  = 3'b100;
    localparam logic [2:0] OpDec  = 3'b101;
    localparam logic [2:0] OpSwap = 3'b110;
    localparam logic [2:0] OpRsv  = 3'b111;

    localparam logic [2:0] FunClr  = 3'b000;
    localparam logic [2:0] FunLoad = 3'b001;
    localparam logic [2:0] FunInc  = 3'b010;
    localparam logic [2:0] FunDec  = 3'b011;

    // S4 is the SWAP temporary
    localparam logic [2:0] IdxTmp = 3'd7;

    typedef enum logic [1:0] {StIdle, StExec, StRd, StWr} state_e;

    state_e      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [2:0]  op_q, dst_q, src_q;
    logic [31:0] imm_q;
    logic        accept;

    function automatic logic is_reject(input logic [2:0] op, input logic [2:0] dst,
                                       input logic [2:0] src);
        return (op == OpRsv) ||
               ((op == OpSwap) && ((src == dst) || (src == IdxTmp) || (dst == IdxTmp)));
    endfunction

    assign cmd.cmd_ready = (state_q == StIdle);
    assign accept        = cmd.cmd_valid && (state_q == StIdle);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            step_q  <= 2'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            op_q    <= OpNop;
            dst_q   <= 3'd0;
            src_q   <= 3'd0;
            imm_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (accept) begin
                op_q  <= cmd.cmd_op;
                dst_q <= cmd.cmd_dst;
                src_q <= cmd.cmd_src;
                imm_q <= cmd.cmd_imm;
            end
        end
    end

    // Next-state logic. NOP and rejected commands spend one cycle in EXEC with no write.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                step_d = 2'd0;
                if (accept) begin
                    if ((cmd.cmd_op == OpMov) ||
                        ((cmd.cmd_op == OpSwap) &&
                         !is_reject(cmd.cmd_op, cmd.cmd_dst, cmd.cmd_src))) begin
                        state_d = StRd;
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StExec: begin
                state_d = StIdle;
                done_d  = 1'b1;
                err_d   = is_reject(op_q, dst_q, src_q);
            end
            StRd: begin
                state_d = StWr;
            end
            StWr: begin
                if ((op_q == OpSwap) && (step_q != 2'd2)) begin
                    state_d = StRd;
                    step_d  = step_q + 2'd1;
                end else begin
                    state_d = StIdle;
                    step_d  = 2'd0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                step_d  = 2'd0;
            end
        endcase
    end

    // Read/write indices of the current move; SWAP walks dst->S4, src->dst, S4->src.
    logic [2:0] rd_idx, wr_idx;

    always_comb begin
        rd_idx = src_q;
        wr_idx = dst_q;
        if (op_q == OpSwap) begin
            case (step_q)
                2'd0: begin
                    rd_idx = dst_q;
                    wr_idx = IdxTmp;
                end
                2'd1: begin
                    rd_idx = src_q;
                    wr_idx = dst_q;
                end
                default: begin
                    rd_idx = IdxTmp;
                    wr_idx = src_q;
                end
            endcase
        end
    end

    logic        wr_en;
    logic [2:0]  wr_fun;
    logic [31:0] wr_data;

    always_comb begin
        wr_en   = 1'b0;
        wr_fun  = FunClr;
        wr_data = 32'd0;
        OutASel = 3'd0;
        case (state_q)
            StExec: begin
                case (op_q)
                    OpLdi: begin
                        wr_en   = 1'b1;
                        wr_fun  = FunLoad;
                        wr_data = imm_q;
                    end
                    OpClr: begin
                        wr_en  = 1'b1;
                        wr_fun = FunClr;
                    end
                    OpInc: begin
                        wr_en  = 1'b1;
                        wr_fun = FunInc;
                    end
                    OpDec: begin
                        wr_en  = 1'b1;
                        wr_fun = FunDec;
                    end
                    default: begin
                        wr_en = 1'b0;
                    end
                endcase
            end
            StRd: begin
                OutASel = rd_idx;
            end
            StWr: begin
                OutASel = rd_idx;
                wr_en   = 1'b1;
                wr_fun  = FunLoad;
                wr_data = rf_outa;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    always_comb begin
        RegSel = 4'd0;
        ScrSel = 4'd0;
        FunSel = FunClr;
        I      = 32'd0;
        if (wr_en) begin
            if (wr_idx[2]) begin
                ScrSel[wr_idx[1:0]] = 1'b1;
            end else begin
                RegSel[wr_idx[1:0]] = 1'b1;
            end
            FunSel = wr_fun;
            I      = wr_data;
        end
    end

    assign OutBSel = 3'b000;
    assign done    = done_q;
    assign err     = err_q;

endmodule
